rej_ntt_poly: RTL and testbench
===============================

# rej_ntt_poly

Rejection sampler for ML-DSA ExpandA. It sits directly upstream of the ExpandA controller. On `start_rej` it requests a SHAKE128 stream seeded with the current (i, j) indices. It consumes 64-bit squeeze lanes, unpacks them into 3-byte candidates and rejects every candidate ≥ q. It emits exactly 256 accepted coefficients on `z_out`/`z_valid`, then pulses `done_rej`.

## Interface
- `Q`, 8380417: ML-DSA modulus; acceptance bound.
- `N_COEF`, 256: coefficients per polynomial.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start_rej`  in  1: one-cycle start pulse; sampled only in IDLE.
- `i`  in  8: row index, latched at start.
- `j`  in  8: column index, latched at start.
- `xof_start`  out  1: one-cycle pulse to SHAKE128 to absorb rho‖j‖i and begin squeezing.
- `xof_idx`  out  16: `{i, j}`; byte 0 (`[7:0]`) = j, byte 1 (`[15:8]`) = i. Held stable from `xof_start` until `done_rej`.
- `lane_data`  in  64: squeeze lane, little-endian; byte 0 = `[7:0]`.
- `lane_valid`  in  1: lane_data valid.
- `lane_ready`  out  1: lane accepted when `lane_valid && lane_ready`.
- `xof_stop`  out  1: one-cycle pulse telling SHAKE128 to stop squeezing; coincides with `done_rej`.
- `z_out`  out  24: accepted coefficient, range 0..Q-1, upper bit 23 always 0.
- `z_valid`  out  1: one-cycle qualifier for z_out; no backpressure.
- `done_rej`  out  1: one-cycle pulse after the 256th coefficient.

## Operation
- States are IDLE → SEED → STREAM → FLUSH → IDLE.
- IDLE: the block latches i/j on `start_rej` and clears the byte buffer and the 9-bit accept counter.
- SEED: `xof_start` is 1 for exactly this cycle. Next state is STREAM.
- STREAM operates on a 16-byte buffer with a 5-bit byte count `cnt`.
  - Lane intake: `lane_ready` = (`cnt` ≤ 8). An accepted lane appends 8 bytes after the existing ones.
  - Triple extraction: when `cnt` ≥ 3, the oldest 3 bytes b0, b1, b2 are removed in that cycle.
  - Candidate: c = b0 + 2^8·b1 + 2^16·(b2 & 0x7F), a 23-bit value. Bit 7 of b2 is discarded.
  - Accept if c < Q. Accepted candidates are registered into `z_out` with `z_valid`=1 on the next cycle, and the accept counter increments.
  - Lane append and triple removal in the same cycle are allowed: `cnt_next` = `cnt` + 8 − 3. The buffer never exceeds 16 bytes.
- When the counter reaches 256, the block moves to FLUSH. No further triples are evaluated and `lane_ready` = 0.
- FLUSH: `done_rej` = 1 and `xof_stop` = 1 for one cycle. The buffer and `cnt` clear, and leftover bytes are discarded. Next state is IDLE.
- `start_rej` outside IDLE is ignored.
- `lane_valid` outside STREAM is not accepted, because `lane_ready` = 0 there.

## Timing
- Reset values: `xof_start`=0, `xof_idx`=0, `lane_ready`=0, `xof_stop`=0, `z_out`=0, `z_valid`=0, `done_rej`=0, state=IDLE, `cnt`=0, counter=0.
- An asynchronous reset mid-operation returns to IDLE immediately. Any partial polynomial is abandoned and no `done_rej` is issued.
- Latency: `start_rej` at cycle t gives `xof_start` at t+1 and STREAM from t+2.
- A lane accepted at cycle k is extractable at k+1. An accepted triple evaluated at cycle m drives `z_valid` at m+1.
- The 256th `z_valid` occurs in the cycle before `done_rej`. The downstream controller therefore sees the final write before the done pulse.
- Throughput is at most one candidate per cycle. Sustained lane intake is 3 lanes per 8 cycles.
- `z_valid` and `done_rej` are never high in the same cycle.
- `z_out` holds its last value when `z_valid`=0.

## Structure
- Shared package `dilithium_pkg`: `Q`, `N_COEF`, coefficient width (24), lane width (64), SHAKE128 rate in bytes (168).
- Sub-module `rej_byte_buffer` is the lane-to-triple unpacker.
  - It owns the 16-byte buffer, `cnt`, `lane_ready` and the triple output with its valid.
  - It takes a `flush` input.
- The top level contains the FSM, the comparator, the accept counter and the output registers.

## Test plan
- Lane 0x0000_0000_0003_0201, then zeros → first `z_out`=0x030201 (197121). Bytes 3–5 (0x00,0x00,0x00) give z_out=0.
- Triple FF,FF,FF (c=8388607) → rejected, no `z_valid`. Triple 01,E0,7F (c=8380417=Q) → rejected.
- Triple 00,E0,7F → accepted, `z_out`=8380416. Triple 00,00,80 → accepted, `z_out`=0, confirming top-bit masking.
- Random lanes with `lane_valid` toggling randomly → exactly 256 `z_valid` pulses, then `done_rej` and `xof_stop` on the following cycle. Every coefficient matches a FIPS 204 RejNTTPoly reference model for the given i=2, j=1 (`xof_idx`=0x0201).
- Triples straddling lane boundaries (byte counts 8→5→2→10) → correct byte order, and `cnt` never exceeds 16.
- `rst_n` asserted after 100 coefficients → all outputs return to their reset values at once. A subsequent `start_rej` restarts the count from 0.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants and the sampler state type.
package dilithium_pkg;
    localparam int unsigned Q             = 8380417;
    localparam int unsigned N_COEF        = 256;
    localparam int unsigned COEF_W        = 24;
    localparam int unsigned LANE_W        = 64;
    localparam int unsigned SHAKE128_RATE = 168;
    localparam int unsigned BUF_BYTES     = 16;

    localparam logic [COEF_W-1:0] Q_COEF = COEF_W'(Q);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_STREAM,
        ST_FLUSH
    } rej_state_t;
endpackage

// File: rtl/rej_ntt_poly_if.sv
// SHAKE128 control and squeeze-lane handshake between the sampler and the XOF.
interface rej_ntt_poly_if;
    import dilithium_pkg::*;

    logic              xof_start;
    logic [15:0]       xof_idx;
    logic              xof_stop;
    logic [LANE_W-1:0] lane_data;
    logic              lane_valid;
    logic              lane_ready;

    modport master (output xof_start, xof_idx, xof_stop, lane_ready,
                    input  lane_data, lane_valid);
    modport slave  (input  xof_start, xof_idx, xof_stop, lane_ready,
                    output lane_data, lane_valid);
endinterface

// File: rtl/rej_byte_buffer.sv
// Lane-to-triple unpacker: 16-byte FIFO-ordered buffer, byte 0 is the oldest.
module rej_byte_buffer
    import dilithium_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic [LANE_W-1:0] lane_data,
    input  logic              lane_valid,
    output logic              lane_ready,
    output logic [22:0]       cand,
    output logic              cand_valid
);
    logic [8*BUF_BYTES-1:0] bytes_q;
    logic [8*BUF_BYTES-1:0] shifted;
    logic [8*BUF_BYTES-1:0] bytes_n;
    logic [4:0]             cnt;
    logic [4:0]             cnt_base;
    logic [4:0]             cnt_n;
    logic                   push;

    assign lane_ready = enable && (cnt <= 5'd8);
    assign cand_valid = enable && (cnt >= 5'd3);
    // bit 7 of the third byte is dropped here, giving the 23-bit candidate
    assign cand       = bytes_q[22:0];
    assign push       = lane_valid && lane_ready;

    // bytes above cnt are kept zero so a new lane can be OR-ed in after the survivors
    always_comb begin
        shifted  = cand_valid ? (bytes_q >> 24) : bytes_q;
        cnt_base = cand_valid ? (cnt - 5'd3) : cnt;
        bytes_n  = shifted;
        cnt_n    = cnt_base;
        if (push) begin
            bytes_n = shifted | ({{(8*BUF_BYTES-LANE_W){1'b0}}, lane_data} << {cnt_base, 3'b000});
            cnt_n   = cnt_base + 5'd8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bytes_q <= '0;
            cnt     <= '0;
        end else if (flush) begin
            bytes_q <= '0;
            cnt     <= '0;
        end else begin
            bytes_q <= bytes_n;
            cnt     <= cnt_n;
        end
    end
endmodule

// File: rtl/rej_ntt_poly.sv
// ML-DSA ExpandA rejection sampler: turns a SHAKE128 stream into 256 coefficients < Q.
// state  | meaning
// IDLE   | wait for start_rej, latch (i, j)
// SEED   | pulse xof_start
// STREAM | take lanes, test one candidate per cycle until 256 accepted
// FLUSH  | pulse done_rej/xof_stop, drop leftover bytes
module rej_ntt_poly
    import dilithium_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_rej,
    input  logic [7:0]        i,
    input  logic [7:0]        j,
    rej_ntt_poly_if.master    xof,
    output logic [COEF_W-1:0] z_out,
    output logic              z_valid,
    output logic              done_rej
);
    rej_state_t  state, state_n;
    logic [15:0] idx;
    logic [8:0]  acc_cnt;
    logic        buf_en;
    logic        buf_flush;
    logic [22:0] cand;
    logic        cand_valid;
    logic        accept;

    rej_byte_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (buf_en),
        .flush      (buf_flush),
        .lane_data  (xof.lane_data),
        .lane_valid (xof.lane_valid),
        .lane_ready (xof.lane_ready),
        .cand       (cand),
        .cand_valid (cand_valid)
    );

    assign accept      = cand_valid && ({1'b0, cand} < Q_COEF);
    assign xof.xof_idx = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // once 256 are accepted the buffer is frozen for the last z_valid cycle, then FLUSH
    always_comb begin
        state_n       = state;
        xof.xof_start = 1'b0;
        xof.xof_stop  = 1'b0;
        done_rej      = 1'b0;
        buf_en        = 1'b0;
        buf_flush     = 1'b1;
        case (state)
            ST_IDLE: if (start_rej) state_n = ST_SEED;
            ST_SEED: begin
                xof.xof_start = 1'b1;
                state_n       = ST_STREAM;
            end
            ST_STREAM: begin
                buf_flush = 1'b0;
                if (acc_cnt == 9'(N_COEF)) state_n = ST_FLUSH;
                else                       buf_en  = 1'b1;
            end
            ST_FLUSH: begin
                done_rej     = 1'b1;
                xof.xof_stop = 1'b1;
                state_n      = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            acc_cnt <= '0;
            z_out   <= '0;
            z_valid <= 1'b0;
        end else begin
            if (state == ST_IDLE && start_rej) begin
                idx     <= {i, j};
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + 9'd1;
            end
            z_valid <= accept;
            if (accept) z_out <= {1'b0, cand};
        end
    end
endmodule

// File: tb/tb_rej_ntt_poly.sv
// Randomized bench for rej_ntt_poly against a byte-stream RejNTTPoly model.
module tb_rej_ntt_poly;
    import dilithium_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_rej = 1'b0;
    logic [7:0]  i = 8'd0;
    logic [7:0]  j = 8'd0;
    logic [23:0] z_out;
    logic        z_valid;
    logic        done_rej;

    rej_ntt_poly_if xif();

    rej_ntt_poly dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_rej (start_rej),
        .i         (i),
        .j         (j),
        .xof       (xif),
        .z_out     (z_out),
        .z_valid   (z_valid),
        .done_rej  (done_rej)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit [63:0]   lanes[$];
    int          exp_q[$];
    logic [23:0] zq[$];
    int          li, cyc, last_zv, done_cyc, stop_cyc, overlap, max_cnt;
    bit          done_seen;
    logic [15:0] idx_at_done;

    bit [7:0] dir_b [21] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hE0, 8'h7F, 8'h00, 8'hE0, 8'h7F,
                             8'h00, 8'h00, 8'h80};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic make_lanes(input bit directed);
        bit [7:0]  bq[$];
        bit [63:0] w;
        if (directed) foreach (dir_b[k]) bq.push_back(dir_b[k]);
        while (bq.size() < 130 * 8) bq.push_back(8'($urandom));
        lanes.delete();
        for (int l = 0; l < 130; l++) begin
            w = '0;
            for (int b = 0; b < 8; b++) w[8*b +: 8] = bq[8*l + b];
            lanes.push_back(w);
        end
    endtask

    // RejNTTPoly on the byte string formed by the lanes in order
    task automatic ref_poly();
        int nb, b0, b1, b2, c;
        exp_q.delete();
        nb = lanes.size() * 8;
        for (int k = 0; k + 3 <= nb && exp_q.size() < int'(N_COEF); k += 3) begin
            b0 = int'((lanes[k/8]       >> (8*(k%8)))       & 64'hFF);
            b1 = int'((lanes[(k+1)/8]   >> (8*((k+1)%8)))   & 64'hFF);
            b2 = int'((lanes[(k+2)/8]   >> (8*((k+2)%8)))   & 64'hFF);
            c  = b0 + 256 * b1 + 65536 * (b2 % 128);
            if (c < int'(Q)) exp_q.push_back(c);
        end
    endtask

    task automatic start_poly();
        @(negedge clk);
        check_val("xof_start_idle", xif.xof_start, 1'b0);
        i = 8'd2; j = 8'd1; start_rej = 1'b1;
        @(negedge clk);
        start_rej = 1'b0;
        check_val("xof_start_seed", xif.xof_start, 1'b1);
        check_val("xof_idx_seed", xif.xof_idx, 16'h0201);
        check_val("lane_ready_seed", xif.lane_ready, 1'b0);
    endtask

    task automatic stream(input int stop_at);
        int budget;
        bit rdy;
        budget = 4000;
        zq.delete();
        li = 0; cyc = 0; last_zv = -1; done_cyc = -10; stop_cyc = -20;
        overlap = 0; max_cnt = 0; done_seen = 1'b0; idx_at_done = '0;
        while (!done_seen && budget > 0 && zq.size() < stop_at) begin
            @(negedge clk);
            cyc++;
            if (z_valid) begin zq.push_back(z_out); last_zv = cyc; end
            if (done_rej) begin done_seen = 1'b1; done_cyc = cyc; idx_at_done = xif.xof_idx; end
            if (xif.xof_stop) stop_cyc = cyc;
            if (z_valid && done_rej) overlap++;
            if (int'(dut.u_buf.cnt) > max_cnt) max_cnt = int'(dut.u_buf.cnt);
            xif.lane_valid = ($urandom_range(0, 3) != 0) && (li < lanes.size());
            xif.lane_data  = (li < lanes.size()) ? lanes[li] : 64'd0;
            rdy = xif.lane_ready;
            @(posedge clk);
            if (xif.lane_valid && rdy) li++;
            budget--;
        end
        xif.lane_valid = 1'b0;
        if (!done_seen && zq.size() < stop_at) check_val("stream_timeout", 0, 1);
    endtask

    task automatic full_run(input bit directed);
        make_lanes(directed);
        ref_poly();
        start_poly();
        stream(100000);
        check_val("done_seen", done_seen, 1'b1);
        check_val("z_count", zq.size(), N_COEF);
        for (int k = 0; k < zq.size() && k < exp_q.size(); k++)
            check_val($sformatf("coef[%0d]", k), zq[k], exp_q[k]);
        check_val("done_after_last_z", done_cyc, last_zv + 1);
        check_val("stop_with_done", stop_cyc, done_cyc);
        check_val("z_done_overlap", overlap, 0);
        check_val("xof_idx_held", idx_at_done, 16'h0201);
        check_val("cnt_max_le16", max_cnt <= 16, 1'b1);
        if (directed) begin
            if (zq.size() >= 5) begin
                check_val("dir_z0", zq[0], 24'd197121);
                check_val("dir_z1", zq[1], 24'd0);
                check_val("dir_z2", zq[2], 24'd0);
                check_val("dir_z3_qm1", zq[3], 24'd8380416);
                check_val("dir_z4_mask", zq[4], 24'd0);
            end else check_val("dir_z_size", zq.size(), 5);
        end
        @(negedge clk);
        check_val("done_one_cycle", done_rej, 1'b0);
        check_val("lane_ready_idle", xif.lane_ready, 1'b0);
    endtask

    initial begin
        xif.lane_valid = 1'b0;
        xif.lane_data  = '0;
        #12;
        check_val("rst_z_valid", z_valid, 1'b0);
        check_val("rst_z_out", z_out, 24'd0);
        check_val("rst_done", done_rej, 1'b0);
        check_val("rst_xof_start", xif.xof_start, 1'b0);
        check_val("rst_xof_stop", xif.xof_stop, 1'b0);
        check_val("rst_xof_idx", xif.xof_idx, 16'd0);
        check_val("rst_lane_ready", xif.lane_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        xif.lane_valid = 1'b1;
        @(negedge clk);
        check_val("idle_no_ready", xif.lane_ready, 1'b0);
        xif.lane_valid = 1'b0;

        full_run(1'b1);

        // abort after 100 coefficients
        make_lanes(1'b0);
        ref_poly();
        start_poly();
        stream(100);
        check_val("abort_z_count", zq.size(), 100);
        check_val("abort_no_done", done_seen, 1'b0);
        for (int k = 0; k < zq.size() && k < exp_q.size(); k++)
            check_val($sformatf("abort_coef[%0d]", k), zq[k], exp_q[k]);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_z_valid", z_valid, 1'b0);
        check_val("arst_z_out", z_out, 24'd0);
        check_val("arst_done", done_rej, 1'b0);
        check_val("arst_xof_start", xif.xof_start, 1'b0);
        check_val("arst_xof_stop", xif.xof_stop, 1'b0);
        check_val("arst_xof_idx", xif.xof_idx, 16'd0);
        check_val("arst_lane_ready", xif.lane_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        full_run(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
